// File: rtl/multiword_add_arbiter_pkg.sv
// Shared types and sizing helpers for the multiword add arbiter.
package multiword_add_arbiter_pkg;

    // Sequencer states; encodings are fixed so waveforms read the same everywhere.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Slice index width: clog2(WORDS), never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Full operand width.
    function automatic int op_width(input int n, input int words);
        return n * words;
    endfunction

endpackage

// File: rtl/multiword_add_arbiter_if.sv
// Two requester channels plus one result channel, all valid/ready.
interface multiword_add_arbiter_if #(
    parameter int N     = 8,
    parameter int WORDS = 4
);
    import multiword_add_arbiter_pkg::*;

    localparam int W = op_width(N, WORDS);

    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ci;
    logic         req0_ready;

    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ci;
    logic         req1_ready;

    logic         res_valid;
    logic [W-1:0] res_sum;
    logic         res_co;
    logic         res_id;
    logic         res_ready;

    // Producers/consumer side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_ci,
        output req1_valid, req1_a, req1_b, req1_ci,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_co, res_id
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ci,
        input  req1_valid, req1_a, req1_b, req1_ci,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_co, res_id
    );

endinterface

// File: rtl/multiword_add_arbiter_adder.sv
// n-bit ripple-carry adder used as the shared slice datapath.
module fullRippleAdder #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         ci,
    output logic [n-1:0] s,
    output logic         co
);

    // Carry ripples LSB to MSB through one full-adder cell per bit.
    always_comb begin : p_ripple
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/multiword_add_arbiter.sv
// Round-robin shares one N-bit adder between two requesters and runs each
// N*WORDS-bit add as WORDS slice adds, LSW first, joined by a registered carry.
module multiword_add_arbiter
    import multiword_add_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multiword_add_arbiter_if.slave bus
);

    localparam int              W          = op_width(N, WORDS);
    localparam int              IW         = idx_width(WORDS);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(WORDS - 1);
    localparam logic [W-1:0]    SLICE_MASK = W'({N{1'b1}});

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          rr_last_q, rr_last_d;
    logic          id_q, id_d;

    logic          grant0, grant1;
    logic [31:0]   slice_sh;
    logic [N-1:0]  slice_a, slice_b, slice_s;
    logic          slice_co;

    // Grant: a lone requester wins; on contention the one that was not served last wins.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | rr_last_q);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~rr_last_q);
    end

    assign bus.req0_ready = (state_q == S_IDLE) & grant0;
    assign bus.req1_ready = (state_q == S_IDLE) & grant1;

    // Select the current slice of the latched operands; nothing else feeds the adder.
    always_comb begin
        slice_sh = 32'(idx_q) * 32'(N);
        slice_a  = N'(a_q >> slice_sh);
        slice_b  = N'(b_q >> slice_sh);
    end

    fullRippleAdder #(.n(N)) u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Result comes straight from registers so it holds steady while stalled.
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res_sum   = sum_q;
    assign bus.res_co    = carry_q;
    assign bus.res_id    = id_q;

    // Next-state: accept in IDLE, one slice per RUN cycle, hold in DONE until taken.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        rr_last_d = rr_last_q;
        id_d      = id_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant0 | grant1) begin
                    id_d    = grant1;
                    a_d     = grant1 ? bus.req1_a  : bus.req0_a;
                    b_d     = grant1 ? bus.req1_b  : bus.req0_b;
                    carry_d = grant1 ? bus.req1_ci : bus.req0_ci;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q & ~(SLICE_MASK << slice_sh)) | (W'(slice_s) << slice_sh);
                carry_d = slice_co;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IDX_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    rr_last_d = id_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            rr_last_q <= 1'b1;
            id_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            rr_last_q <= rr_last_d;
            id_q      <= id_d;
        end
    end

endmodule

// File: tb/tb_multiword_add_arbiter.sv
// Randomized plus directed bench with a transaction-level reference model.
module tb_multiword_add_arbiter;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiword_add_arbiter_if #(.N(N), .WORDS(WORDS)) bus ();
    multiword_add_arbiter_if #(.N(N), .WORDS(1))     bus1 ();

    multiword_add_arbiter #(.N(N), .WORDS(WORDS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    multiword_add_arbiter #(.N(N), .WORDS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Model: one expected result per accepted op, in acceptance order.
    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         id;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic         rr_last  = 1'b1;
    bit           seen     = 0;
    int           act_lat  = 0;
    bit           acc0, acc1, hs;
    logic [W-1:0] hs_sum;
    logic         hs_co, hs_id;
    int           hs_lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called once per cycle at the falling edge: check outputs, then advance the model.
    task automatic compare();
        exp_t         h, e;
        bit           busy, er0, er1, ev;
        logic [W:0]   full;
        cyc++;
        acc0 = 0;
        acc1 = 0;
        hs   = 0;
        if (!rst_n) begin
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_res_sum", bus.res_sum, 0);
            chk("rst_res_co_id", {bus.res_co, bus.res_id}, 0);
            exp_q.delete();
            rr_last = 1'b1;
            seen    = 0;
            return;
        end
        busy = (exp_q.size() != 0);
        er0  = !busy && bus.req0_valid && (!bus.req1_valid || rr_last != 1'b0);
        er1  = !busy && bus.req1_valid && (!bus.req0_valid || rr_last != 1'b1);
        chk("req_ready", {bus.req1_ready, bus.req0_ready}, {er1, er0});
        if (busy) begin
            h  = exp_q[0];
            ev = (cyc - h.acc) >= WORDS + 1;
            chk("res_valid", bus.res_valid, ev);
            if (bus.res_valid && !seen) begin
                seen    = 1;
                act_lat = cyc - h.acc;
            end
            if (ev) begin
                chk("res_sum", bus.res_sum, h.sum);
                chk("res_co", bus.res_co, h.co);
                chk("res_id", bus.res_id, h.id);
                if (bus.res_ready) begin
                    hs     = 1;
                    hs_sum = bus.res_sum;
                    hs_co  = bus.res_co;
                    hs_id  = bus.res_id;
                    hs_lat = act_lat;
                    rr_last = h.id;
                    seen    = 0;
                    void'(exp_q.pop_front());
                end
            end
        end else begin
            chk("res_valid_idle", bus.res_valid, 0);
        end
        if (er0) begin
            full  = {1'b0, bus.req0_a} + {1'b0, bus.req0_b} + (W+1)'(bus.req0_ci);
            e.sum = full[W-1:0];
            e.co  = full[W];
            e.id  = 1'b0;
            e.acc = cyc;
            exp_q.push_back(e);
            acc0 = 1;
        end
        if (er1) begin
            full  = {1'b0, bus.req1_a} + {1'b0, bus.req1_b} + (W+1)'(bus.req1_ci);
            e.sum = full[W-1:0];
            e.co  = full[W];
            e.id  = 1'b1;
            e.acc = cyc;
            exp_q.push_back(e);
            acc1 = 1;
        end
    endtask

    // One clock: compare at the falling edge, then retire accepted requests after the rising edge.
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        if (acc0) bus.req0_valid = 1'b0;
        if (acc1) bus.req1_valid = 1'b0;
    endtask

    task automatic wait_hs(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!hs && n < 60);
        if (!hs) begin
            checks++;
            failures++;
            $display("FAIL %s: no result within 60 cycles", name);
        end
    endtask

    task automatic drive(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_ci = ci;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_ci = ci;
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r;
        case ($urandom_range(0, 3))
            0:       r = '1;
            1:       r = '0;
            default: r = W'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        int n;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ci = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ci = 0;
        bus.res_ready  = 1;
        bus1.req0_valid = 0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_ci = 0;
        bus1.req1_valid = 0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_ci = 0;
        bus1.res_ready  = 1;

        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single requester, carry across the first slice boundary.
        drive(0, 32'h000000FF, 32'h00000001, 1'b0);
        wait_hs("t1");
        chk("t1_sum", hs_sum, 32'h00000100);
        chk("t1_co", hs_co, 0);
        chk("t1_id", hs_id, 0);
        chk("t1_latency", hs_lat, 5);

        // Carry ripples through every slice.
        drive(1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        wait_hs("t2");
        chk("t2_sum", hs_sum, 32'h00000000);
        chk("t2_co", hs_co, 1);
        chk("t2_id", hs_id, 1);

        // Contention from reset: req0 first, then req1, then req0 again.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        drive(0, 32'h1, 32'h1, 1'b0);
        drive(1, 32'h1, 32'h1, 1'b0);
        wait_hs("t3a");
        chk("t3a_id", hs_id, 0);
        chk("t3a_sum", hs_sum, 32'h2);
        wait_hs("t3b");
        chk("t3b_id", hs_id, 1);
        drive(0, 32'h1, 32'h1, 1'b0);
        drive(1, 32'h1, 32'h1, 1'b0);
        wait_hs("t3c");
        chk("t3c_id", hs_id, 0);
        wait_hs("t3d");
        chk("t3d_id", hs_id, 1);

        // Stall in DONE for 10 cycles with the other requester waiting.
        drive(0, 32'hDEADBEEF, 32'h01010101, 1'b1);
        bus.res_ready = 1'b0;
        repeat (WORDS + 2) step();
        drive(1, 32'h80000000, 32'h80000000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_ready_hold", {bus.req1_ready, bus.req0_ready}, 0);
            chk("t4_valid_hold", bus.res_valid, 1);
        end
        bus.res_ready = 1'b1;
        wait_hs("t4a");
        chk("t4a_sum", hs_sum, 32'hDFAEBFF1);
        chk("t4a_co", hs_co, 0);
        wait_hs("t4b");
        chk("t4b_sum", hs_sum, 32'h00000000);
        chk("t4b_co", hs_co, 1);

        // Reset two cycles into RUN drops the op.
        drive(0, 32'h12345678, 32'h11111111, 1'b0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", bus.res_valid, 0);
        step();
        rst_n = 1'b1;
        repeat (8) step();
        drive(0, 32'h12345678, 32'h11111111, 1'b0);
        wait_hs("t5");
        chk("t5_sum", hs_sum, 32'h23456789);
        chk("t5_co", hs_co, 0);

        // Single-slice build.
        bus1.req0_valid = 1'b1; bus1.req0_a = 8'hFF; bus1.req0_b = 8'h01; bus1.req0_ci = 1'b1;
        @(negedge clk);
        chk("t6_ready", bus1.req0_ready, 1);
        @(posedge clk);
        #1;
        bus1.req0_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.res_valid && n < 10);
        chk("t6_latency", n, 2);
        chk("t6_sum", bus1.res_sum, 8'h01);
        chk("t6_co", bus1.res_co, 1);
        chk("t6_id", bus1.res_id, 0);
        @(posedge clk);
        #1;

        // Random traffic on the wide build.
        for (int i = 0; i < 600; i++) begin
            step();
            if (!bus.req0_valid && $urandom_range(0, 1) == 1)
                drive(0, rnd_w(), rnd_w(), 1'($urandom_range(0, 1)));
            if (!bus.req1_valid && $urandom_range(0, 1) == 1)
                drive(1, rnd_w(), rnd_w(), 1'($urandom_range(0, 1)));
            bus.res_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        repeat (20) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
